// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game round/match sequencer.
package tank_pkg;

  typedef enum logic [2:0] {
    ST_TITLE      = 3'd0,
    ST_MAZE_REQ   = 3'd1,
    ST_MAZE_WAIT  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_ROUND_OVER = 3'd4,
    ST_MATCH_OVER = 3'd5
  } round_state_t;

  localparam logic [1:0] GE_PLAY = 2'b00;
  localparam logic [1:0] GE_T1   = 2'b01;
  localparam logic [1:0] GE_T2   = 2'b10;
  localparam logic [1:0] GE_LOAD = 2'b11;

  localparam logic [7:0] KEY_ENTER = 8'h28;

endpackage

// File: rtl/frame_timer.sv
// 8-bit loadable down-counter stepped by frame ticks; shared by the maze
// timeout and the post-round pause.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done,
  output logic       expire
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (frame_tick && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);
  // Final tick of the interval, so callers can leave on that same edge.
  assign expire = frame_tick && (count == 8'd1);

endmodule

// File: rtl/round_sequencer.sv
// Round and match sequencer: Enter decode, maze request/timeout, hit
// arbitration, scoring, post-round pause and match winner.
//
// state         | meaning
// TITLE         | title screen, waiting for Enter
// MAZE_REQ      | one-cycle maze_start pulse, timeout loaded
// MAZE_WAIT     | waiting for maze_ready, re-request on timeout
// PLAY          | tanks move, first hit report ends the round
// ROUND_OVER    | frozen pause showing the round result
// MATCH_OVER    | winner shown until Enter
module round_sequencer
  import tank_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned MAZE_TIMEOUT = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic [31:0] keycode,
  input  logic        tank1shot,
  input  logic        tank2shot,
  input  logic        maze_ready,
  output logic        maze_start,
  output logic        title,
  output logic [1:0]  game_end,
  output logic        freeze,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  match_winner
);

  localparam logic [3:0] WIN4    = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD8   = 8'(HOLD_FRAMES);
  localparam logic [7:0] TIMEOUT8 = 8'(MAZE_TIMEOUT);

  round_state_t state, state_n;
  logic         enter, enter_q, enter_prev, enter_rise;
  logic [1:0]   result;
  logic         timer_load, timer_done, timer_expire, time_up;
  logic [7:0]   timer_value;
  logic         win_reached;

  assign enter = (keycode[7:0]   == KEY_ENTER) || (keycode[15:8]  == KEY_ENTER) ||
                 (keycode[23:16] == KEY_ENTER) || (keycode[31:24] == KEY_ENTER);
  assign enter_rise  = enter_q && !enter_prev;
  assign time_up     = timer_expire || timer_done;
  assign win_reached = (score1 == WIN4) || (score2 == WIN4);

  frame_timer u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .frame_tick (frame_tick),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done),
    .expire     (timer_expire)
  );

  always_comb begin
    state_n     = state;
    timer_load  = 1'b0;
    timer_value = 8'd0;
    case (state)
      ST_TITLE:      if (enter_rise) state_n = ST_MAZE_REQ;
      ST_MAZE_REQ: begin
        timer_load  = 1'b1;
        timer_value = TIMEOUT8;
        state_n     = ST_MAZE_WAIT;
      end
      ST_MAZE_WAIT: begin
        if (maze_ready)   state_n = ST_PLAY;
        else if (time_up) state_n = ST_MAZE_REQ;
      end
      ST_PLAY: begin
        if (tank1shot || tank2shot) begin
          timer_load  = 1'b1;
          timer_value = HOLD8;
          state_n     = ST_ROUND_OVER;
        end
      end
      ST_ROUND_OVER: if (time_up) state_n = win_reached ? ST_MATCH_OVER : ST_MAZE_REQ;
      ST_MATCH_OVER: if (enter_rise) state_n = ST_TITLE;
      default:       state_n = ST_TITLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_TITLE;
      enter_q      <= 1'b0;
      enter_prev   <= 1'b0;
      maze_start   <= 1'b0;
      score1       <= 4'd0;
      score2       <= 4'd0;
      result       <= GE_PLAY;
      match_winner <= 2'b00;
    end else begin
      state      <= state_n;
      enter_q    <= enter;
      enter_prev <= enter_q;
      maze_start <= (state_n == ST_MAZE_REQ);
      case (state)
        ST_TITLE: begin
          if (enter_rise) begin
            score1       <= 4'd0;
            score2       <= 4'd0;
            match_winner <= 2'b00;
          end
        end
        ST_PLAY: begin
          // Simultaneous hits are a draw and leave both scores alone.
          if (tank1shot && tank2shot) begin
            result <= GE_LOAD;
          end else if (tank1shot) begin
            result <= GE_T2;
            if (score2 < WIN4) score2 <= score2 + 4'd1;
          end else if (tank2shot) begin
            result <= GE_T1;
            if (score1 < WIN4) score1 <= score1 + 4'd1;
          end
        end
        ST_ROUND_OVER: begin
          if (time_up && win_reached)
            match_winner <= (score1 == WIN4) ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    title    = (state == ST_TITLE);
    freeze   = (state != ST_PLAY);
    game_end = GE_PLAY;
    case (state)
      ST_MAZE_REQ, ST_MAZE_WAIT:      game_end = GE_LOAD;
      ST_ROUND_OVER, ST_MATCH_OVER:   game_end = result;
      default:                        game_end = GE_PLAY;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with short pause/timeout parameters.
module tb_round_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        frame_tick = 1'b0;
  logic [31:0] keycode = 32'd0;
  logic        tank1shot = 1'b0;
  logic        tank2shot = 1'b0;
  logic        maze_ready = 1'b0;
  logic        maze_start, title, freeze;
  logic [1:0]  game_end, match_winner;
  logic [3:0]  score1, score2;

  int vectors = 0;
  int miscompares = 0;
  int ms_cnt = 0;
  int ms0;

  round_sequencer #(.WIN_SCORE(5), .HOLD_FRAMES(3), .MAZE_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .keycode(keycode),
    .tank1shot(tank1shot), .tank2shot(tank2shot), .maze_ready(maze_ready),
    .maze_start(maze_start), .title(title), .game_end(game_end), .freeze(freeze),
    .score1(score1), .score2(score2), .match_winner(match_winner)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (maze_start) ms_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic ready_pulse();
    maze_ready = 1'b1;
    cyc(1);
    maze_ready = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    check("rst_title", 32'(title), 32'd1);
    check("rst_game_end", 32'(game_end), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd1);
    check("rst_maze_start", 32'(maze_start), 32'd0);
    check("rst_scores", {24'd0, score1, score2}, 32'd0);
    check("rst_winner", 32'(match_winner), 32'd0);
    RESET = 1'b0;
    cyc(2);

    // Enter held for 100 cycles: one request, two-cycle latency
    ms0 = ms_cnt;
    keycode = 32'h0000_2800;
    cyc(1);
    check("enter_n1_no_req", 32'(maze_start), 32'd0);
    check("enter_n1_title", 32'(title), 32'd1);
    cyc(1);
    check("enter_n2_req", 32'(maze_start), 32'd1);
    check("enter_n2_title", 32'(title), 32'd0);
    cyc(1);
    check("req_one_cycle", 32'(maze_start), 32'd0);
    check("wait_game_end", 32'(game_end), 32'd3);
    check("wait_freeze", 32'(freeze), 32'd1);
    cyc(97);
    keycode = 32'd0;
    check("enter_hold_one_req", 32'(ms_cnt - ms0), 32'd1);

    // maze_ready after 10 cycles
    cyc(10);
    ready_pulse();
    check("play_game_end", 32'(game_end), 32'd0);
    check("play_freeze", 32'(freeze), 32'd0);

    // maze_ready during PLAY ignored
    ms0 = ms_cnt;
    maze_ready = 1'b1;
    cyc(3);
    maze_ready = 1'b0;
    cyc(1);
    check("ready_in_play_freeze", 32'(freeze), 32'd0);
    check("ready_in_play_no_req", 32'(ms_cnt - ms0), 32'd0);

    // Tank 1 hit: tank 2 scores
    tank1shot = 1'b1;
    cyc(1);
    tank1shot = 1'b0;
    check("t1hit_score2", 32'(score2), 32'd1);
    check("t1hit_score1", 32'(score1), 32'd0);
    check("t1hit_game_end", 32'(game_end), 32'd2);
    check("t1hit_freeze", 32'(freeze), 32'd1);
    tick();
    tick();
    check("pause_2ticks_no_req", 32'(maze_start), 32'd0);
    check("pause_result_held", 32'(game_end), 32'd2);
    tick();
    check("pause_3ticks_req", 32'(maze_start), 32'd1);
    cyc(1);

    // Timeout: re-request after 4 ticks without maze_ready
    tick();
    tick();
    tick();
    check("timeout_3_no_req", 32'(maze_start), 32'd0);
    check("timeout_loading", 32'(game_end), 32'd3);
    tick();
    check("timeout_4_req", 32'(maze_start), 32'd1);
    cyc(1);
    ready_pulse();
    check("play2_freeze", 32'(freeze), 32'd0);

    // Draw, then a shot in ROUND_OVER ignored
    tank1shot = 1'b1;
    tank2shot = 1'b1;
    cyc(1);
    tank1shot = 1'b0;
    tank2shot = 1'b0;
    check("draw_game_end", 32'(game_end), 32'd3);
    check("draw_scores", {24'd0, score1, score2}, 32'h01);
    tank2shot = 1'b1;
    cyc(1);
    tank2shot = 1'b0;
    check("shot_in_pause_ignored", 32'(score1), 32'd0);
    tick();
    tick();
    tick();
    check("draw_pause_req", 32'(maze_start), 32'd1);
    cyc(1);
    ready_pulse();

    // Tank 2 hit five times: tank 1 takes the match
    for (int i = 0; i < 5; i++) begin
      tank2shot = 1'b1;
      cyc(1);
      tank2shot = 1'b0;
      check("t2hit_score1", 32'(score1), 32'(i + 1));
      check("t2hit_game_end", 32'(game_end), 32'd1);
      tick();
      tick();
      tick();
      if (i < 4) begin
        check("next_round_req", 32'(maze_start), 32'd1);
        cyc(1);
        ready_pulse();
      end
    end
    check("match_no_req", 32'(maze_start), 32'd0);
    check("match_winner_t1", 32'(match_winner), 32'd1);
    check("match_game_end", 32'(game_end), 32'd1);
    check("match_freeze", 32'(freeze), 32'd1);
    cyc(5);
    check("match_no_req_later", 32'(maze_start), 32'd0);

    // Enter -> TITLE, winner still shown
    keycode = 32'h2800_0000;
    cyc(2);
    keycode = 32'd0;
    check("title_again", 32'(title), 32'd1);
    check("title_winner_held", 32'(match_winner), 32'd1);
    check("title_game_end", 32'(game_end), 32'd0);
    cyc(2);

    // Next Enter starts a fresh match
    keycode = 32'h0000_0028;
    cyc(2);
    keycode = 32'd0;
    check("new_match_scores", {24'd0, score1, score2}, 32'd0);
    check("new_match_winner", 32'(match_winner), 32'd0);
    check("new_match_req", 32'(maze_start), 32'd1);
    cyc(1);
    ready_pulse();
    tank1shot = 1'b1;
    cyc(1);
    tank1shot = 1'b0;
    check("pre_reset_score2", 32'(score2), 32'd1);

    // Asynchronous reset mid-ROUND_OVER
    tick();
    #3;
    RESET = 1'b1;
    #1;
    check("async_title", 32'(title), 32'd1);
    check("async_scores", {24'd0, score1, score2}, 32'd0);
    check("async_maze_start", 32'(maze_start), 32'd0);
    check("async_game_end", 32'(game_end), 32'd0);
    check("async_freeze", 32'(freeze), 32'd1);
    #1;
    RESET = 1'b0;
    cyc(3);
    check("post_reset_title", 32'(title), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
